// File: rtl/stream_edge_pipeline.sv
// Streaming 3x3 edge filter between a UART RX FIFO and a UART TX FIFO.
// A frame is START_CHAR, IMAGE_WIDTH*IMAGE_HIGHT pixel bytes in raster order,
// then STOP_CHAR. The frame is re-emitted as START_CHAR, the interior filter
// results in raster order, then STOP_CHAR. Two line buffers plus a two-column
// window shift register give the full 3x3 neighbourhood as each pixel arrives.
//
// Handshakes: read_uart pops the RX FIFO head (rx_data) in the same cycle and
// is only ever high while rx_empty is low. write_uart pushes tx_data in the
// same cycle and is only ever high while tx_full is low. A single holding
// register (hold_v/hold_d) is the only source of TX bytes.
module stream_edge_pipeline #(
  parameter int                    IMAGE_WIDTH = 8,
  parameter int                    IMAGE_HIGHT = 8,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] START_CHAR  = 8'd90,
  parameter logic [DATA_WIDTH-1:0] STOP_CHAR   = 8'd90
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_empty,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  read_uart,
  input  logic                  tx_full,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  write_uart,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic [2:0]            state
);

  localparam int CW = (IMAGE_WIDTH > 2) ? $clog2(IMAGE_WIDTH) : 2;
  localparam int RW = (IMAGE_HIGHT > 2) ? $clog2(IMAGE_HIGHT) : 2;
  localparam int SW = DATA_WIDTH + 3;

  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PIX  = 3'd2,
    S_CHK  = 3'd3,
    S_TAIL = 3'd4
  } state_e;

  state_e                state_q;
  logic [1:0]            mode_q;
  logic [RW-1:0]         row_q;
  logic [CW-1:0]         col_q;
  logic                  hold_v_q;
  logic [DATA_WIDTH-1:0] hold_d_q;
  logic                  stop_loaded_q;
  logic                  frame_done_q;
  logic                  frame_error_q;

  // Line buffers: lb0 holds row r-1, lb1 holds row r-2 (contents not reset).
  logic [DATA_WIDTH-1:0] lb0_q [IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_q [IMAGE_WIDTH];
  // Window columns c-2 (wa) and c-1 (wb): top = row r-2, mid = r-1, bot = r.
  logic [DATA_WIDTH-1:0] wa_top_q, wa_mid_q, wa_bot_q;
  logic [DATA_WIDTH-1:0] wb_top_q, wb_mid_q, wb_bot_q;

  logic                  hold_free;
  logic                  pop;
  logic                  window_done;
  logic                  last_pix;
  logic [DATA_WIDTH-1:0] lb_top, lb_mid;
  logic [SW-1:0]         gx, gy, abs_gx, abs_gy, mag;
  logic [DATA_WIDTH-1:0] result;

  function automatic logic [SW-1:0] ext(input logic [DATA_WIDTH-1:0] v);
    return {3'b000, v};
  endfunction

  // Hold can accept a new byte if it is empty or its byte leaves this cycle.
  assign hold_free  = !hold_v_q || !tx_full;
  assign write_uart = hold_v_q && !tx_full;
  assign tx_data    = hold_d_q;
  assign read_uart  = pop && reset_n;
  assign busy       = (state_q != S_IDLE);
  assign state      = state_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;

  assign lb_top      = lb1_q[col_q];
  assign lb_mid      = lb0_q[col_q];
  assign window_done = (state_q == S_PIX) && pop && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
  assign last_pix    = (row_q == ROW_LAST) && (col_q == COL_LAST);

  // RX pop decision: IDLE discards freely; pixel and stop bytes wait for hold space.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      S_IDLE:       pop = !rx_empty;
      S_PIX, S_CHK: pop = !rx_empty && hold_free;
      default:      pop = 1'b0;
    endcase
  end

  // Sobel magnitudes for the window completed by the current pixel.
  always_comb begin
    gx = (ext(lb_top) + (ext(lb_mid) << 1) + ext(rx_data))
       - (ext(wa_top_q) + (ext(wa_mid_q) << 1) + ext(wa_bot_q));
    gy = (ext(wa_bot_q) + (ext(wb_bot_q) << 1) + ext(rx_data))
       - (ext(wa_top_q) + (ext(wb_top_q) << 1) + ext(lb_top));
    abs_gx = gx[SW-1] ? (~gx + 1'b1) : gx;
    abs_gy = gy[SW-1] ? (~gy + 1'b1) : gy;
    case (mode_q)
      2'd0:    mag = abs_gx;
      2'd1:    mag = abs_gy;
      2'd2:    mag = abs_gx + abs_gy;
      default: mag = ext(wb_mid_q);
    endcase
    if (|mag[SW-1:DATA_WIDTH]) result = {DATA_WIDTH{1'b1}};
    else                       result = mag[DATA_WIDTH-1:0];
  end

  // Line buffer and window shift on every accepted pixel.
  always_ff @(posedge clk) begin
    if (state_q == S_PIX && pop) begin
      lb0_q[col_q] <= rx_data;
      lb1_q[col_q] <= lb0_q[col_q];
      wa_top_q <= wb_top_q;
      wa_mid_q <= wb_mid_q;
      wa_bot_q <= wb_bot_q;
      wb_top_q <= lb_top;
      wb_mid_q <= lb_mid;
      wb_bot_q <= rx_data;
    end
  end

  // Frame FSM, counters, holding register and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      mode_q        <= 2'd0;
      row_q         <= '0;
      col_q         <= '0;
      hold_v_q      <= 1'b0;
      hold_d_q      <= '0;
      stop_loaded_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      if (write_uart) hold_v_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop && rx_data == START_CHAR) begin
            mode_q  <= mode;
            row_q   <= '0;
            col_q   <= '0;
            state_q <= S_HDR;
          end
        end
        S_HDR: begin
          if (hold_free) begin
            hold_v_q <= 1'b1;
            hold_d_q <= START_CHAR;
            state_q  <= S_PIX;
          end
        end
        S_PIX: begin
          if (pop) begin
            if (window_done) begin
              hold_v_q <= 1'b1;
              hold_d_q <= result;
            end
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
            if (last_pix) state_q <= S_CHK;
          end
        end
        S_CHK: begin
          if (pop) begin
            if (rx_data == STOP_CHAR) begin
              state_q <= S_TAIL;
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= S_IDLE;
            end
          end
        end
        S_TAIL: begin
          if (!stop_loaded_q) begin
            if (hold_free) begin
              hold_v_q      <= 1'b1;
              hold_d_q      <= STOP_CHAR;
              stop_loaded_q <= 1'b1;
            end
          end else if (write_uart) begin
            stop_loaded_q <= 1'b0;
            frame_done_q  <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_edge_pipeline.sv
// Bench for stream_edge_pipeline: a byte-queue RX source, a random TX
// back-pressure source, a reference model that filters a whole image array,
// and a monitor that checks every pushed TX byte against the expected queue.
module tb_stream_edge_pipeline;

  localparam int W = 8;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       read_uart;
  logic       tx_full;
  logic [7:0] tx_data;
  logic       write_uart;
  logic [1:0] mode = 2'd0;
  logic       busy;
  logic       frame_done;
  logic       frame_error;
  logic [2:0] state;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] img [H][W];

  int  checks = 0;
  int  failures = 0;
  int  pops = 0;
  int  got_done = 0;
  int  got_err = 0;
  int  exp_done = 0;
  int  exp_err = 0;
  bit  gap_en = 1'b0;
  bit  full_rand = 1'b0;
  bit  force_full = 1'b0;
  bit  scramble = 1'b0;

  stream_edge_pipeline dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .read_uart   (read_uart),
    .tx_full     (tx_full),
    .tx_data     (tx_data),
    .write_uart  (write_uart),
    .mode        (mode),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_error (frame_error),
    .state       (state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #600000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // RX source and TX back-pressure: drive at negedge, observe pops just before posedge.
  initial begin
    rx_empty = 1'b1;
    rx_data  = 8'd0;
    tx_full  = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_q.size() > 0 && !(gap_en && $urandom_range(0, 4) == 0)) begin
        rx_empty = 1'b0;
        rx_data  = rx_q[0];
      end else begin
        rx_empty = 1'b1;
        rx_data  = 8'($urandom_range(0, 255));
      end
      tx_full = force_full || (full_rand && $urandom_range(0, 3) == 0);
      #4;
      if (read_uart && rx_q.size() > 0) begin
        void'(rx_q.pop_front());
        pops++;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (read_uart) begin
        checks++;
        if (rx_empty) begin
          failures++;
          $display("FAIL rx_handshake read_uart=1 while rx_empty=%0d", rx_empty);
        end
      end
      if (write_uart) begin
        checks++;
        if (tx_full) begin
          failures++;
          $display("FAIL tx_handshake write_uart=1 while tx_full=%0d", tx_full);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL tx_byte got=%0d exp=<none>", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            failures++;
            $display("FAIL tx_byte got=%0d exp=%0d", tx_data, e);
          end
        end
      end
      if (frame_done)  got_done++;
      if (frame_error) got_err++;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_read_uart"},   int'(read_uart),   0);
    chk({nm, "_write_uart"},  int'(write_uart),  0);
    chk({nm, "_tx_data"},     int'(tx_data),     0);
    chk({nm, "_busy"},        int'(busy),        0);
    chk({nm, "_frame_done"},  int'(frame_done),  0);
    chk({nm, "_frame_error"}, int'(frame_error), 0);
    chk({nm, "_state"},       int'(state),       0);
  endtask

  // Reference filter for the output centred on (r,c).
  function automatic int model(input int m, input int r, input int c);
    int gx, gy, v;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    case (m)
      0: v = gx;
      1: v = gy;
      2: v = gx + gy;
      default: v = img[r][c];
    endcase
    return (v > 255) ? 255 : v;
  endfunction

  // Queue expected TX bytes, then the RX bytes of one frame.
  task automatic push_frame(input int m, input logic [7:0] stop, input bit pre);
    mode = 2'(m);
    exp_q.push_back(8'd90);
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++)
        exp_q.push_back(8'(model(m, r, c)));
    if (stop == 8'd90) begin
      exp_q.push_back(8'd90);
      exp_done++;
    end else begin
      exp_err++;
    end
    if (pre) begin
      rx_q.push_back(8'h11);
      rx_q.push_back(8'h22);
    end
    rx_q.push_back(8'd90);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        rx_q.push_back(img[r][c]);
    rx_q.push_back(stop);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!(rx_q.size() == 0 && exp_q.size() == 0 && !busy) && n < 3000) begin
      @(negedge clk);
      if (busy && scramble) mode = 2'($urandom_range(0, 3));
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout rx_left=%0d exp_left=%0d", nm, rx_q.size(), exp_q.size());
    end
    repeat (3) @(negedge clk);
    chk({nm, "_frame_done_count"},  got_done, exp_done);
    chk({nm, "_frame_error_count"}, got_err,  exp_err);
  endtask

  task automatic wait_pops(input int target);
    int n = 0;
    while (pops < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL pop_wait got=%0d exp=%0d", pops, target);
    end
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
  endtask

  task automatic fill_split();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < 4) ? 8'd0 : 8'd255;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'(8*r + c);
  endtask

  // Main sequence
  initial begin
    int base;
    int busy_pops;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    chk_outputs_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    gap_en = 1'b1;
    full_rand = 1'b1;

    // Flat image in mode 0
    fill_const(8'd100);
    push_frame(0, 8'd90, 1'b0);
    wait_done("flat_m0");

    // Vertical step edge in modes 0, 1 and 2
    fill_split();
    push_frame(0, 8'd90, 1'b0);
    wait_done("split_m0");
    push_frame(1, 8'd90, 1'b0);
    wait_done("split_m1");
    push_frame(2, 8'd90, 1'b0);
    wait_done("split_m2");

    // Passthrough of the centre pixel, then with framing-valued pixels inside
    fill_ramp();
    push_frame(3, 8'd90, 1'b0);
    wait_done("ramp_m3");
    img[3][3] = 8'd90;
    img[5][1] = 8'd90;
    img[0][7] = 8'd90;
    push_frame(3, 8'd90, 1'b0);
    wait_done("ramp90_m3");

    // Leading garbage and a bad stop byte, then a good frame
    fill_split();
    push_frame(0, 8'h55, 1'b1);
    wait_done("badstop");
    fill_const(8'd100);
    push_frame(0, 8'd90, 1'b0);
    wait_done("after_err");

    // TX stalled mid-frame: no RX pops once hold is stuck full
    gap_en = 1'b0;
    full_rand = 1'b0;
    fill_split();
    base = pops;
    push_frame(0, 8'd90, 1'b0);
    wait_pops(base + 30);
    force_full = 1'b1;
    busy_pops = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #4;
      if (i >= 10 && read_uart) busy_pops++;
    end
    chk("stall_rx_pops", busy_pops, 0);
    force_full = 1'b0;
    wait_done("stall");
    gap_en = 1'b1;
    full_rand = 1'b1;

    // Reset in the middle of a frame
    fill_const(8'd100);
    base = pops;
    push_frame(0, 8'd90, 1'b0);
    wait_pops(base + 20);
    @(negedge clk);
    reset_n = 1'b0;
    rx_q.delete();
    exp_q.delete();
    exp_done--;  // the aborted frame never reaches its stop byte
    @(negedge clk);
    #4;
    chk_outputs_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    push_frame(0, 8'd90, 1'b0);
    wait_done("post_reset");

    // Random images, random modes, mode toggling mid-frame
    scramble = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          img[r][c] = ($urandom_range(0, 7) == 0) ? 8'd90 : 8'($urandom_range(0, 255));
      push_frame(int'($urandom_range(0, 3)), 8'd90, 1'b0);
      wait_done("random");
    end
    scramble = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
